// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode, funct, FSM-state and ALU-control constants for the multicycle MIPS controller
//   state_t : FSM state encoding (FETCH=0 .. JEX=11; codes 12-15 unused)
//   ctrl_t  : bundle of Moore control outputs produced for each state
//   moore() : per-state control decode, shared by reset and normal state updates
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

    // Unused encodings fall through to all-zero so no strobe can fire from them.
    function automatic ctrl_t moore(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.irwrite = 1'b1;
                c.pcwrite = 1'b1;
                c.alusrcb = SRCB_FOUR;
            end
            DECODE:  c.alusrcb = SRCB_IMMSH2;
            MEMADR, ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
            end
            MEMRD:   c.iord = 1'b1;
            MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            RTYPEEX: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            BEQEX: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_SUB;
                c.pcsrc   = PCSRC_ALUOUT;
                c.branch  = 1'b1;
            end
            ADDIWB:  c.regwrite = 1'b1;
            JEX: begin
                c.pcsrc   = PCSRC_JUMP;
                c.pcwrite = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_mc_controller_if.sv
// mips_mc_controller_if: instruction/flag inputs and control outputs between datapath and controller
//   op, funct, zero     : datapath -> controller (IR fields, ALU zero flag)
//   pcen .. alucontrol  : controller -> datapath (enables, strobes, mux selects, ALU op)
//   illegal, state      : controller -> observer (bad-opcode/funct pulse, debug state)
//   master modport = datapath/bench side, slave modport = controller side
interface mips_mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
    logic [3:0] state;

    modport master (
        output op, funct, zero,
        input  pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, alucontrol, illegal, state
    );

    modport slave (
        input  op, funct, zero,
        output pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, alucontrol, illegal, state
    );
endinterface

// File: rtl/mips_aludec.sv
// mips_aludec: maps the controller's aluop and the R-type funct field onto a 3-bit ALU operation
//   aluop[1:0]      : 00 add, 01 subtract, 10 use funct
//   funct[5:0]      : instr[5:0]
//   alucontrol[2:0] : ALU operation code
//   badfunct        : funct is not a supported R-type operation while aluop selects funct
module mips_aludec
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       badfunct
);
    logic [2:0] w_fn;
    logic       w_known;

    // Unsupported functs still execute as add so the instruction completes harmlessly.
    always_comb begin
        w_known = 1'b1;
        case (funct)
            F_ADD:   w_fn = ALU_ADD;
            F_SUB:   w_fn = ALU_SUB;
            F_AND:   w_fn = ALU_AND;
            F_OR:    w_fn = ALU_OR;
            F_SLT:   w_fn = ALU_SLT;
            default: begin
                w_fn    = ALU_ADD;
                w_known = 1'b0;
            end
        endcase
    end

    assign alucontrol = (aluop == ALUOP_SUB)   ? ALU_SUB :
                        (aluop == ALUOP_FUNCT) ? w_fn    : ALU_ADD;
    assign badfunct   = (aluop == ALUOP_FUNCT) && !w_known;
endmodule

// File: rtl/mips_mc_controller.sv
// mips_mc_controller: multicycle MIPS control FSM (lw, sw, R-type, beq, addi, j)
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, forces FETCH from any state
//   bus   : mips_mc_controller_if.slave -- op/funct/zero in, control strobes,
//           mux selects, alucontrol, illegal pulse and debug state out
module mips_mc_controller
    import mips_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    mips_mc_controller_if.slave   bus
);
    state_t r_state;
    state_t w_next;
    ctrl_t  r_ctrl;
    logic   w_badop;
    logic   w_badfunct;

    assign w_badop = !(bus.op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});

    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:   w_next = DECODE;
            DECODE:  w_next = (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR  :
                              (bus.op == OP_RTYPE)                 ? RTYPEEX :
                              (bus.op == OP_BEQ)                   ? BEQEX   :
                              (bus.op == OP_ADDI)                  ? ADDIEX  :
                              (bus.op == OP_J)                     ? JEX     : FETCH;
            MEMADR:  w_next = (bus.op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   w_next = MEMWB;
            RTYPEEX: w_next = RTYPEWB;
            ADDIEX:  w_next = ADDIWB;
            default: w_next = FETCH;
        endcase
    end

    // Moore outputs are registered alongside the state by decoding the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
            r_ctrl  <= moore(FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= moore(w_next);
        end
    end

    mips_aludec u_aludec (
        .aluop      (r_ctrl.aluop),
        .funct      (bus.funct),
        .alucontrol (bus.alucontrol),
        .badfunct   (w_badfunct)
    );

    // Branch resolution uses this cycle's zero flag, so pcen stays combinational.
    assign bus.pcen     = r_ctrl.pcwrite | (r_ctrl.branch & bus.zero);
    assign bus.iord     = r_ctrl.iord;
    assign bus.memwrite = r_ctrl.memwrite;
    assign bus.irwrite  = r_ctrl.irwrite;
    assign bus.regwrite = r_ctrl.regwrite;
    assign bus.regdst   = r_ctrl.regdst;
    assign bus.memtoreg = r_ctrl.memtoreg;
    assign bus.alusrca  = r_ctrl.alusrca;
    assign bus.alusrcb  = r_ctrl.alusrcb;
    assign bus.pcsrc    = r_ctrl.pcsrc;
    assign bus.illegal  = (r_state == DECODE && w_badop) || (r_state == RTYPEEX && w_badfunct);
    assign bus.state    = r_state;
endmodule

// File: tb/tb_mips_mc_controller.sv
// tb_mips_mc_controller: random and directed instruction streams checked against a path-table model
module tb_mips_mc_controller;
    typedef int iq_t[$];

    logic clk = 1'b0;
    logic reset = 1'b1;
    mips_mc_controller_if bus();

    mips_mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_state = 0;
    iq_t  q;
    bit   armed = 1'b0;
    logic [3:0]  s_st   [8];
    logic        s_pcen [8];
    logic        s_ill  [8];
    logic        s_rw   [8];
    logic [2:0]  s_alu  [8];
    logic [1:0]  s_pcsrc[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Cycles from FETCH to the next FETCH for each instruction class.
    function automatic int lat(input logic [5:0] o);
        case (o)
            6'b100011:                       return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000010:            return 3;
            default:                         return 2;
        endcase
    endfunction

    // States visited after FETCH for each instruction class.
    function automatic iq_t path(input logic [5:0] o);
        case (o)
            6'b100011: return '{1, 2, 3, 4};
            6'b101011: return '{1, 2, 5};
            6'b000000: return '{1, 6, 7};
            6'b000100: return '{1, 8};
            6'b001000: return '{1, 9, 10};
            6'b000010: return '{1, 11};
            default:   return '{1};
        endcase
    endfunction

    function automatic bit okop(input logic [5:0] o);
        return o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    function automatic bit goodf(input logic [5:0] f);
        return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    function automatic logic [2:0] fmap(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // {pcwrite, branch, iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca, alusrcb, pcsrc}
    function automatic logic [12:0] exp_moore(input int s);
        case (s)
            0:       return 13'b1_0_0_0_1_0_0_0_0_01_00;
            1:       return 13'b0_0_0_0_0_0_0_0_0_11_00;
            2, 9:    return 13'b0_0_0_0_0_0_0_0_1_10_00;
            3:       return 13'b0_0_1_0_0_0_0_0_0_00_00;
            4:       return 13'b0_0_0_0_0_1_0_1_0_00_00;
            5:       return 13'b0_0_1_1_0_0_0_0_0_00_00;
            6:       return 13'b0_0_0_0_0_0_0_0_1_00_00;
            7:       return 13'b0_0_0_0_0_1_1_0_0_00_00;
            8:       return 13'b0_1_0_0_0_0_0_0_1_00_01;
            10:      return 13'b0_0_0_0_0_1_0_0_0_00_00;
            11:      return 13'b1_0_0_0_0_0_0_0_0_00_10;
            default: return 13'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            exp_state = 0;
            armed = 1'b1;
        end else if (armed) begin
            if (q.size() == 0 && exp_state != 0) exp_state = 0;
            else begin
                if (q.size() == 0) q = path(bus.op);
                exp_state = q.pop_front();
            end
        end
    end

    always @(negedge clk) begin
        logic [12:0] e;
        if (armed) begin
            e = exp_moore(exp_state);
            chk("state", 32'(bus.state), 32'(exp_state));
            chk("ctrl", 32'({bus.iord, bus.memwrite, bus.irwrite, bus.regwrite, bus.regdst,
                             bus.memtoreg, bus.alusrca, bus.alusrcb, bus.pcsrc}), 32'(e[10:0]));
            chk("pcen", 32'(bus.pcen), 32'(e[12] | (e[11] & bus.zero)));
            chk("alucontrol", 32'(bus.alucontrol),
                32'(exp_state == 8 ? 3'b110 : exp_state == 6 ? fmap(bus.funct) : 3'b010));
            chk("illegal", 32'(bus.illegal),
                32'((exp_state == 1 && !okop(bus.op)) || (exp_state == 6 && !goodf(bus.funct))));
        end
    end

    // zmode 0/1 holds zero constant; 2 randomizes it every cycle.
    task automatic instr(input logic [5:0] o, input logic [5:0] f, input int zmode);
        bus.op = o;
        bus.funct = f;
        bus.zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
        for (int i = 0; i < lat(o); i++) begin
            @(negedge clk);
            s_st[i] = bus.state;
            s_pcen[i] = bus.pcen;
            s_ill[i] = bus.illegal;
            s_rw[i] = bus.regwrite;
            s_alu[i] = bus.alucontrol;
            s_pcsrc[i] = bus.pcsrc;
            @(posedge clk);
            #1;
            if (zmode == 2) bus.zero = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        logic [5:0] ops [6];
        logic [5:0] fns [5];
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        bus.op = 6'b0;
        bus.funct = 6'b0;
        bus.zero = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        instr(6'b100011, 6'b0, 0);
        chk("lw states", 32'({s_st[0], s_st[1], s_st[2], s_st[3], s_st[4]}), 32'h01234);
        chk("lw regwrite", 32'({s_rw[0], s_rw[1], s_rw[2], s_rw[3], s_rw[4]}), 32'b00001);
        chk("lw pcen", 32'({s_pcen[0], s_pcen[1], s_pcen[2], s_pcen[3], s_pcen[4]}), 32'b10000);
        instr(6'b101011, 6'b0, 0);
        chk("sw states", 32'({s_st[0], s_st[1], s_st[2], s_st[3]}), 32'h0125);
        instr(6'b000000, 6'b101010, 0);
        chk("slt alucontrol", 32'(s_alu[2]), 32'h7);
        chk("slt states", 32'({s_st[2], s_st[3]}), 32'h67);
        instr(6'b000000, 6'b100010, 0);
        chk("sub alucontrol", 32'(s_alu[2]), 32'h6);
        instr(6'b000100, 6'b0, 1);
        chk("beq taken pcen", 32'(s_pcen[2]), 32'h1);
        chk("beq taken pcsrc", 32'(s_pcsrc[2]), 32'h1);
        instr(6'b000100, 6'b0, 0);
        chk("beq not taken pcen", 32'(s_pcen[2]), 32'h0);
        instr(6'b111111, 6'b0, 0);
        chk("illegal op pulse", 32'({s_ill[0], s_ill[1]}), 32'b01);
        chk("illegal op states", 32'({s_st[0], s_st[1]}), 32'h01);
        instr(6'b000000, 6'b111111, 0);
        chk("bad funct alucontrol", 32'(s_alu[2]), 32'h2);
        chk("bad funct pulse", 32'({s_ill[2], s_ill[3]}), 32'b10);
        bus.op = 6'b100011;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre-reset MEMRD", 32'(bus.state), 32'h3);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        instr(6'b000010, 6'b0, 0);
        chk("j after reset states", 32'({s_st[0], s_st[1], s_st[2]}), 32'h01b);
        chk("j pcen", 32'(s_pcen[2]), 32'h1);
        chk("j pcsrc", 32'(s_pcsrc[2]), 32'h2);
        chk("no wb after reset", 32'(s_rw[0]), 32'h0);
        for (int k = 0; k < 200; k++) begin
            logic [5:0] o;
            logic [5:0] f;
            o = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 5)] : 6'($urandom);
            f = ($urandom_range(0, 9) < 7) ? fns[$urandom_range(0, 4)] : 6'($urandom);
            instr(o, f, 2);
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_mc_controller.md
MIPS_MC_CONTROLLER -- requirements
Module: mips_mc_controller

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by the MIPS32 ISA.
REQ-002 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  6  instr[31:26] from the instruction register.
REQ-005 funct  input  6  instr[5:0] from the instruction register.
REQ-006 zero  input  1  ALU zero flag for the current cycle.
REQ-007 pcen  output  1  PC register enable.
REQ-008 iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 memwrite, irwrite, regwrite  output  1 each  memory write, IR write and register-file write strobes.
REQ-010 regdst, memtoreg, alusrca  output  1 each  datapath mux selects.
REQ-011 alusrcb  output  2  ALU B select: 00 = reg B, 01 = const 4, 10 = signimm, 11 = signimm<<2.
REQ-012 pcsrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-013 alucontrol  output  3  ALU operation code.
REQ-014 illegal  output  1  one-cycle pulse in DECODE for an unsupported op, or in RTYPEEX for an unsupported funct.
REQ-015 state  output  4  current FSM state, for debug.

Function
REQ-016 The FSM SHALL use these states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
REQ-017 The supported opcodes SHALL be: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
REQ-018 Transitions:
- FETCH->DECODE.
- DECODE->MEMADR (lw/sw), RTYPEEX (R), BEQEX (beq), ADDIEX (addi), JEX (j), FETCH (any other op).
- MEMADR->MEMRD (lw) or MEMWR (sw).
- MEMRD->MEMWB.
- RTYPEEX->RTYPEWB.
- ADDIEX->ADDIWB.
- MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB and JEX->FETCH.
REQ-019 Encodings 12-15 SHALL transition to FETCH with all strobes deasserted.
REQ-020 Outputs SHALL be a Moore decode of state; any output not listed for a state is 0.
- FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00.
- DECODE: alusrcb=11, aluop=00.
- MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=00.
- MEMRD: iord=1.
- MEMWB: memtoreg=1, regwrite=1.
- MEMWR: iord=1, memwrite=1.
- RTYPEEX: alusrca=1, aluop=10.
- RTYPEWB: regdst=1, regwrite=1.
- BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
- ADDIWB: regwrite=1.
- JEX: pcsrc=10, pcwrite=1.
REQ-021 pcen SHALL be pcwrite OR (branch AND zero), evaluated combinationally in the same cycle.
REQ-022 alucontrol SHALL be decoded from aluop as follows:
- aluop 00 -> 010 (add).
- aluop 01 -> 110 (sub).
- aluop 10, by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; any other funct -> 010.
REQ-023 An illegal op SHALL cause no register or memory write, and the PC SHALL have advanced by exactly 4.
REQ-024 An illegal funct SHALL still complete RTYPEWB with alucontrol=010.
REQ-025 Instruction latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal op 2.

Reset
REQ-026 When reset is high at a clock edge, state SHALL become FETCH, and this SHALL take priority from any state, including mid-instruction.
REQ-027 While in reset, pcen, memwrite, regwrite and illegal SHALL be 0 in the cycle after the edge, apart from the FETCH Moore outputs.
REQ-028 The datapath SHALL hold PC via its own synchronous reset.

Structure
REQ-029 The opcode, funct, state-encoding and alucontrol constants SHALL live in a shared package mips_pkg.
REQ-030 The ALU decode SHALL be a sub-module mips_aludec (inputs aluop[1:0] and funct[5:0]; outputs alucontrol[2:0] and badfunct).
REQ-031 The FSM, the output decode and the pcen logic SHALL live in mips_mc_controller.

Verification
REQ-032 Reset, then lw (op=100011): state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; pcen=1 only in state 0.
REQ-033 sw (op=101011): states 0,1,2,5,0; memwrite=1 and iord=1 in state 5 only; regwrite never asserted.
REQ-034 R-type with funct 101010, then funct 100010: alucontrol=111 in RTYPEEX for the first and 110 for the second; regdst=1 and regwrite=1 in RTYPEWB.
REQ-035 beq with zero=1, then with zero=0: in BEQEX, pcen=1 with pcsrc=01 for the first and pcen=0 for the second; each returns to FETCH after 3 cycles.
REQ-036 op=111111: illegal pulses for 1 cycle in DECODE, the next state is FETCH, and no write strobes are asserted.
REQ-037 Reset asserted while in MEMRD: the next state is FETCH, no MEMWB regwrite occurs, and a following j (op=000010) gives JEX with pcsrc=10 and pcen=1.
